note_detector: RTL and testbench

NOTE_DETECTOR -- requirements
Module: note_detector

---
 rtl/note_detector_pkg.sv | 37 +++
 rtl/note_matcher.sv | 70 +++++++
 rtl/note_detector.sv | 90 +++++++++
 tb/tb_note_detector.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/note_detector_pkg.sv
// Shared constants and types for the note detector: period table, ids, FSM encodings.
package note_detector_pkg;

  localparam int unsigned NUM_NOTES = 25;
  localparam logic [4:0]  SILENT_ID = 5'd31;
  localparam logic [4:0]  LAST_K    = 5'd24;
  localparam logic [11:0] N_MAX     = 12'd4095;
  localparam logic [11:0] TIMEOUT_N = 12'd2048;

  typedef logic [12:0] period_t;

  // Expected 2N (samples per full period) for each note, longest first.
  localparam period_t PERIOD [NUM_NOTES] = '{
    13'd1024, 13'd967, 13'd912, 13'd861, 13'd813,
    13'd767,  13'd724, 13'd683, 13'd645, 13'd609,
    13'd575,  13'd542, 13'd512, 13'd483, 13'd456,
    13'd431,  13'd406, 13'd384, 13'd362, 13'd342,
    13'd323,  13'd304, 13'd287, 13'd271, 13'd256
  };

  typedef enum logic {
    WAIT_FIRST,
    MEASURE
  } meas_state_t;

  typedef enum logic [1:0] {
    M_IDLE,
    M_SEARCH,
    M_FINISH,
    M_HOLD
  } match_state_t;

  function automatic period_t abs_diff(input period_t a, input period_t b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/note_matcher.sv
// Sequential nearest-period search: walks the period table one entry per cycle.
module note_matcher
  import note_detector_pkg::*;
#(
  parameter logic [10:0] TOL = 11'd16
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        start,
  input  logic [12:0] two_n,
  output logic        busy,
  output logic        done,
  output logic [4:0]  id
);

  match_state_t state, state_next;
  period_t      two_n_q;
  period_t      best_diff;
  period_t      cur_diff;
  logic [4:0]   k;
  logic [4:0]   best_k;
  logic         last;

  always_comb begin
    cur_diff = abs_diff(two_n_q, PERIOD[k]);
    last     = (k == LAST_K);
  end

  always_comb begin
    state_next = state;
    case (state)
      M_IDLE:   if (start) state_next = M_SEARCH;
      M_SEARCH: if (last) state_next = M_FINISH;
      M_FINISH: state_next = M_HOLD;
      M_HOLD:   state_next = M_IDLE;
      default:  state_next = M_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= M_IDLE;
      two_n_q   <= '0;
      best_diff <= '1;
      best_k    <= '0;
      k         <= '0;
    end else begin
      state <= state_next;
      if (state == M_IDLE && start) begin
        two_n_q   <= two_n;
        best_diff <= '1;
        best_k    <= '0;
        k         <= '0;
      end else if (state == M_SEARCH) begin
        // Strict compare keeps the lowest index on ties.
        if (cur_diff < best_diff) begin
          best_diff <= cur_diff;
          best_k    <= k;
        end
        if (!last) k <= k + 5'd1;
      end
    end
  end

  // HOLD keeps busy asserted through the cycle the parent registers the result.
  assign busy = (state != M_IDLE);
  assign done = (state == M_FINISH);
  assign id   = (best_diff <= {2'b00, TOL}) ? best_k : SILENT_ID;

endmodule

// File: rtl/note_detector.sv
// Trough detection with hysteresis, half-period counting and note reporting.
module note_detector
  import note_detector_pkg::*;
#(
  parameter logic [9:0]  LOW_THR  = 10'd64,
  parameter logic [9:0]  HIGH_THR = 10'd384,
  parameter logic [10:0] TOL      = 11'd16
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       sample_valid,
  input  logic [9:0] sample,
  output logic [4:0] freq_id,
  output logic       note_valid,
  output logic       overrun,
  output logic       busy
);

  meas_state_t state, state_next;
  logic        armed;
  logic [11:0] n_cnt;
  logic [11:0] n_inc;
  logic        trough;
  logic        timeout;
  logic        start;
  logic        timeout_pend;
  logic        match_done;
  logic [4:0]  match_id;

  // n_inc counts the current sample too, so the captured N equals trough spacing.
  always_comb begin
    n_inc   = (n_cnt == N_MAX) ? n_cnt : n_cnt + 12'd1;
    trough  = armed && sample_valid && (sample < LOW_THR);
    timeout = (state == MEASURE) && sample_valid && !trough && (n_inc == TIMEOUT_N);
    start   = (state == MEASURE) && trough && !busy;
  end

  always_comb begin
    state_next = state;
    case (state)
      WAIT_FIRST: if (trough) state_next = MEASURE;
      MEASURE:    if (timeout) state_next = WAIT_FIRST;
      default:    state_next = WAIT_FIRST;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state        <= WAIT_FIRST;
      armed        <= 1'b0;
      n_cnt        <= '0;
      freq_id      <= SILENT_ID;
      note_valid   <= 1'b0;
      overrun      <= 1'b0;
      timeout_pend <= 1'b0;
    end else begin
      state <= state_next;
      if (sample_valid) begin
        n_cnt <= trough ? '0 : n_inc;
        if (trough) armed <= 1'b0;
        else if (sample >= HIGH_THR) armed <= 1'b1;
      end
      overrun    <= (state == MEASURE) && trough && busy;
      note_valid <= 1'b0;
      // A search result wins a collision; the silence strobe is deferred one cycle.
      if (match_done) begin
        note_valid   <= 1'b1;
        freq_id      <= match_id;
        timeout_pend <= timeout;
      end else if (timeout || timeout_pend) begin
        note_valid   <= 1'b1;
        freq_id      <= SILENT_ID;
        timeout_pend <= 1'b0;
      end
    end
  end

  note_matcher #(
    .TOL(TOL)
  ) u_matcher (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .start  (start),
    .two_n  ({n_inc, 1'b0}),
    .busy   (busy),
    .done   (match_done),
    .id     (match_id)
  );

endmodule

// File: tb/tb_note_detector.sv
// Directed bench for note_detector: trough spacing to note id, overrun, timeout, reset.
module tb_note_detector;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1;
  logic       sample_valid = 1'b0;
  logic [9:0] sample = '0;
  logic [4:0] freq_id;
  logic       note_valid;
  logic       overrun;
  logic       busy;

  note_detector #(
    .LOW_THR (10'd64),
    .HIGH_THR(10'd384),
    .TOL     (11'd16)
  ) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .sample_valid(sample_valid),
    .sample      (sample),
    .freq_id     (freq_id),
    .note_valid  (note_valid),
    .overrun     (overrun),
    .busy        (busy)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  int nv_count = 0;
  int nv_cyc = -1;
  int ov_count = 0;
  int ov_cyc = -1;
  logic [4:0] nv_id = '0;
  int errors = 0;
  int checks = 0;

  always @(posedge clk_in) cyc <= cyc + 1;

  always @(negedge clk_in) begin
    if (note_valid === 1'b1) begin
      nv_count = nv_count + 1;
      nv_cyc   = cyc;
      nv_id    = freq_id;
    end
    if (overrun === 1'b1) begin
      ov_count = ov_count + 1;
      ov_cyc   = cyc;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic send(input logic v, input logic [9:0] s);
    @(negedge clk_in);
    sample_valid = v;
    sample       = s;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(1'b0, 10'd0);
  endtask

  function automatic logic [9:0] filler(input int idx);
    return (idx == 1) ? 10'd200 : 10'd700;
  endfunction

  // Each trough is preceded by spacing-1 non-trough samples; returns the trough's edge number.
  task automatic run_troughs(input int spacing, input int n, input int gap, output int last);
    last = 0;
    for (int t = 0; t < n; t++) begin
      for (int i = 1; i < spacing; i++) begin
        send(1'b1, filler(i));
        idle(gap);
      end
      send(1'b1, 10'd0);
      last = cyc + 1;
      idle(gap);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst_in = 1'b1;
    sample_valid = 1'b0;
    sample = '0;
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (freq_id !== 5'd31) begin errors++; $display("FAIL reset_freq_id: got %0d expected 31", freq_id); end
    checks++; if (note_valid !== 1'b0) begin errors++; $display("FAIL reset_note_valid: got %b expected 0", note_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_spacing(input int spacing, input logic [4:0] exp_id);
    int t;
    int base;
    do_reset();
    base = nv_count;
    run_troughs(spacing, 2, 0, t);
    for (int i = 0; i < 30; i++) begin
      send(1'b0, 10'd0);
      if (cyc == t) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_start_%0d: got %b expected 1", spacing, busy); end
      end
      if (cyc == t + 26) begin
        checks++; if (note_valid !== 1'b1 || freq_id !== exp_id) begin errors++; $display("FAIL note_%0d: got valid=%b id=%0d expected valid=1 id=%0d", spacing, note_valid, freq_id, exp_id); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_last_%0d: got %b expected 1", spacing, busy); end
      end
      if (cyc == t + 27) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_end_%0d: got %b expected 0", spacing, busy); end
      end
    end
    #1;
    checks++; if (nv_count - base !== 1 || nv_cyc !== t + 26) begin errors++; $display("FAIL note_count_%0d: got count=%0d at %0d expected 1 at %0d", spacing, nv_count - base, nv_cyc, t + 26); end
  endtask

  task automatic test_thresholds();
    int base;
    int t;
    do_reset();
    base = nv_count;
    send(1'b1, 10'd384);
    send(1'b1, 10'd0);
    for (int i = 1; i < 256; i++) begin
      if (i == 127 || i == 255) send(1'b1, 10'd384);
      else if (i == 128) send(1'b1, 10'd64);
      else send(1'b1, 10'd383);
    end
    send(1'b1, 10'd0);
    t = cyc + 1;
    idle(40);
    #1;
    checks++; if (nv_count - base !== 1 || nv_id !== 5'd12 || nv_cyc !== t + 26) begin errors++; $display("FAIL thresholds: got count=%0d id=%0d at %0d expected 1 id=12 at %0d", nv_count - base, nv_id, nv_cyc, t + 26); end
  endtask

  task automatic test_back_to_back();
    int tb_, tc, base_nv, base_ov;
    do_reset();
    base_nv = nv_count;
    base_ov = ov_count;
    run_troughs(256, 2, 0, tb_);
    run_troughs(10, 1, 0, tc);
    idle(40);
    #1;
    checks++; if (ov_count - base_ov !== 1 || ov_cyc !== tc) begin errors++; $display("FAIL overrun: got count=%0d at %0d expected 1 at %0d", ov_count - base_ov, ov_cyc, tc); end
    checks++; if (nv_count - base_nv !== 1 || nv_cyc !== tb_ + 26 || nv_id !== 5'd12) begin errors++; $display("FAIL overrun_note: got count=%0d id=%0d at %0d expected 1 id=12 at %0d", nv_count - base_nv, nv_id, nv_cyc, tb_ + 26); end
    checks++; if (freq_id !== 5'd12) begin errors++; $display("FAIL freq_hold: got %0d expected 12", freq_id); end
  endtask

  task automatic test_gaps();
    int t, base;
    do_reset();
    base = nv_count;
    run_troughs(256, 2, 3, t);
    idle(40);
    #1;
    checks++; if (nv_count - base !== 1 || nv_id !== 5'd12 || nv_cyc !== t + 26) begin errors++; $display("FAIL gaps: got count=%0d id=%0d at %0d expected 1 id=12 at %0d", nv_count - base, nv_id, nv_cyc, t + 26); end
  endtask

  task automatic test_timeout();
    int t, t2, base;
    do_reset();
    base = nv_count;
    run_troughs(256, 2, 0, t);
    for (int i = 0; i < 2048; i++) send(1'b1, 10'd700);
    idle(3);
    #1;
    checks++; if (nv_count - base !== 2 || nv_id !== 5'd31 || nv_cyc !== t + 2048) begin errors++; $display("FAIL timeout: got count=%0d id=%0d at %0d expected 2 id=31 at %0d", nv_count - base, nv_id, nv_cyc, t + 2048); end
    run_troughs(300, 2, 0, t2);
    idle(30);
    #1;
    checks++; if (nv_count - base !== 3 || nv_id !== 5'd9 || nv_cyc !== t2 + 26) begin errors++; $display("FAIL after_timeout: got count=%0d id=%0d at %0d expected 3 id=9 at %0d", nv_count - base, nv_id, nv_cyc, t2 + 26); end
  endtask

  task automatic test_reset_mid_search();
    int t, t3, base;
    do_reset();
    base = nv_count;
    run_troughs(256, 2, 0, t);
    for (int i = 0; i < 20 && cyc < t + 11; i++) send(1'b0, 10'd0);
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    checks++; if (busy !== 1'b0 || freq_id !== 5'd31) begin errors++; $display("FAIL mid_reset_state: got busy=%b id=%0d expected busy=0 id=31", busy, freq_id); end
    idle(40);
    #1;
    checks++; if (nv_count !== base) begin errors++; $display("FAIL mid_reset_suppress: got %0d strobes expected 0", nv_count - base); end
    run_troughs(256, 1, 0, t3);
    idle(40);
    #1;
    checks++; if (nv_count !== base) begin errors++; $display("FAIL mid_reset_first: got %0d strobes expected 0", nv_count - base); end
    run_troughs(256, 1, 0, t3);
    idle(30);
    #1;
    checks++; if (nv_count - base !== 1 || nv_id !== 5'd12 || nv_cyc !== t3 + 26) begin errors++; $display("FAIL mid_reset_second: got count=%0d id=%0d at %0d expected 1 id=12 at %0d", nv_count - base, nv_id, nv_cyc, t3 + 26); end
  endtask

  initial begin
    test_reset();
    test_spacing(512, 5'd0);
    test_spacing(256, 5'd12);
    test_spacing(128, 5'd24);
    test_spacing(300, 5'd9);
    test_spacing(700, 5'd31);
    test_thresholds();
    test_back_to_back();
    test_gaps();
    test_timeout();
    test_reset_mid_search();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
